// File: rtl/control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky
// illegal-opcode trap and a retired-instruction counter.
module control_fsm #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr,
  input  logic            mem_ready,
  input  logic            branch_taken,
  output logic [2:0]      state,
  output logic            ir_we,
  output logic            pc_we,
  output logic [1:0]      pc_src,
  output logic            mem_req,
  output logic            mem_we,
  output logic            reg_we,
  output logic [1:0]      wb_sel,
  output logic            alu_src_imm,
  output logic            illegal,
  output logic [BITS-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  state_t          state_q;
  state_t          state_d;
  logic            illegal_q;
  logic [BITS-1:0] instret_q;

  logic is_load, is_store, is_branch, is_fence, is_jal, is_jalr;
  logic is_wb_class, is_legal, uses_imm, rd_nz;

  logic ir_we_c, pc_we_c, mem_req_c, mem_we_c, reg_we_c;

  always_comb begin
    is_load     = (instr[6:0] == OPC_LOAD);
    is_store    = (instr[6:0] == OPC_STORE);
    is_branch   = (instr[6:0] == OPC_BRANCH);
    is_fence    = (instr[6:0] == OPC_FENCE);
    is_jal      = (instr[6:0] == OPC_JAL);
    is_jalr     = (instr[6:0] == OPC_JALR);
    is_wb_class = (instr[6:0] == OPC_OP)    || (instr[6:0] == OPC_OPIMM) ||
                  (instr[6:0] == OPC_LUI)   || (instr[6:0] == OPC_AUIPC) ||
                  is_jal || is_jalr;
    is_legal    = is_wb_class || is_load || is_store || is_branch || is_fence;
    uses_imm    = (instr[6:0] == OPC_OPIMM) || (instr[6:0] == OPC_LUI) ||
                  (instr[6:0] == OPC_AUIPC) || is_load || is_store || is_jalr;
    rd_nz       = (instr[11:7] != 5'd0);
  end

  // Next-state and raw (ungated) control
  always_comb begin
    state_d     = state_q;
    ir_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    reg_we_c    = 1'b0;
    pc_src      = 2'd0;
    wb_sel      = 2'd0;
    alu_src_imm = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = is_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        alu_src_imm = uses_imm;
        if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_branch) begin
          pc_we_c = 1'b1;
          pc_src  = branch_taken ? 2'd1 : 2'd0;
          state_d = S_FETCH;
        end else if (is_fence) begin
          pc_we_c = 1'b1;
          state_d = S_FETCH;
        end else if (is_wb_class) begin
          state_d = S_WB;
        end else begin
          // instr changed after DECODE; refuse to guess
          state_d = S_TRAP;
        end
      end
      S_MEM: begin
        alu_src_imm = uses_imm;
        mem_req_c   = 1'b1;
        mem_we_c    = is_store;
        if (mem_ready) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            pc_we_c = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        alu_src_imm = uses_imm;
        pc_we_c     = 1'b1;
        reg_we_c    = rd_nz;
        pc_src      = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        wb_sel      = is_load ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
        state_d     = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Strobes are held low combinationally for the whole reset assertion
  always_comb begin
    ir_we   = ir_we_c   & rst_n;
    pc_we   = pc_we_c   & rst_n;
    mem_req = mem_req_c & rst_n;
    mem_we  = mem_we_c  & rst_n;
    reg_we  = reg_we_c  & rst_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP) begin
        illegal_q <= 1'b1;
      end
      if (pc_we_c) begin
        instret_q <= instret_q + 1'b1;
      end
    end
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: directed instruction scenarios with literal checks,
// then randomized traffic compared each cycle against a plan-queue model.
module tb_control_fsm;

  localparam int BITS = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [31:0]     instr = 32'd0;
  logic            mem_ready = 1'b0;
  logic            branch_taken = 1'b0;
  logic [2:0]      state;
  logic            ir_we, pc_we, mem_req, mem_we, reg_we, alu_src_imm, illegal;
  logic [1:0]      pc_src, wb_sel;
  logic [BITS-1:0] instret;

  control_fsm #(.BITS(BITS)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .state(state), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we),
    .wb_sel(wb_sel), .alu_src_imm(alu_src_imm), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  localparam int FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5;
  localparam int C_LOAD = 0, C_STORE = 1, C_OPI = 2, C_OP = 3, C_LUI = 4, C_AUIPC = 5,
                 C_JAL = 6, C_JALR = 7, C_BR = 8, C_FENCE = 9, C_ILL = 10;

  int              n_checks = 0;
  int              n_fail = 0;
  int              m_state = FETCH;
  int              m_plan[$];
  logic            m_illegal = 1'b0;
  logic [BITS-1:0] m_instret = '0;
  bit              m_valid = 1'b0;

  function automatic int classify(input logic [31:0] ins);
    case (ins[6:0])
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b0010011: return C_OPI;
      7'b0110011: return C_OP;
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      7'b1100011: return C_BR;
      7'b0001111: return C_FENCE;
      default:    return C_ILL;
    endcase
  endfunction

  function automatic logic [6:0] legal_op(input int k);
    case (k)
      0: return 7'b0000011;
      1: return 7'b0100011;
      2: return 7'b0010011;
      3: return 7'b0110011;
      4: return 7'b0110111;
      5: return 7'b0010111;
      6: return 7'b1101111;
      7: return 7'b1100111;
      8: return 7'b1100011;
      default: return 7'b0001111;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom();
    if ($urandom_range(0, 11) == 0) begin
      op = 7'($urandom_range(0, 127));
      while (classify({25'd0, op}) != C_ILL) op = op + 7'd1;
    end else begin
      op = legal_op(int'($urandom_range(0, 9)));
    end
    return {r[31:7], op};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model for the current cycle, then advance the model.
  task automatic model_cycle();
    int   cls;
    bit   waiting;
    bit   fin;
    bit   imm_cls;
    logic [1:0] e_src;
    logic [1:0] e_wb;
    cls     = classify(instr);
    waiting = ((m_state == FETCH) || (m_state == MEM)) && !mem_ready;
    fin     = rst_n && ((m_state == EXEC) || (m_state == MEM) || (m_state == WB)) &&
              !waiting && (m_plan.size() == 0);
    imm_cls = (cls == C_OPI) || (cls == C_LOAD) || (cls == C_STORE) ||
              (cls == C_LUI) || (cls == C_AUIPC) || (cls == C_JALR);
    e_src   = (cls == C_BR) ? {1'b0, branch_taken} :
              (cls == C_JAL) ? 2'd1 : (cls == C_JALR) ? 2'd2 : 2'd0;
    e_wb    = (cls == C_LOAD) ? 2'd1 : ((cls == C_JAL) || (cls == C_JALR)) ? 2'd2 : 2'd0;
    if (m_valid) begin
      check("m_state", 32'(state), 32'(m_state));
      check("m_illegal", 32'(illegal), 32'(m_illegal));
      check("m_instret", 32'(instret), 32'(m_instret));
      check("m_pc_we", 32'(pc_we), 32'(fin));
      check("m_ir_we", 32'(ir_we), 32'(rst_n && m_state == FETCH && mem_ready));
      check("m_mem_req", 32'(mem_req), 32'(rst_n && (m_state == FETCH || m_state == MEM)));
      check("m_mem_we", 32'(mem_we), 32'(rst_n && m_state == MEM && cls == C_STORE));
      check("m_reg_we", 32'(reg_we), 32'(rst_n && m_state == WB && instr[11:7] != 5'd0));
      if (rst_n) begin
        check("m_alu_src_imm", 32'(alu_src_imm),
              32'(imm_cls && (m_state == EXEC || m_state == MEM || m_state == WB)));
        if (fin) check("m_pc_src", 32'(pc_src), 32'(e_src));
        if (m_state == WB) check("m_wb_sel", 32'(wb_sel), 32'(e_wb));
      end
    end
    if (!rst_n) begin
      m_state   = FETCH;
      m_plan.delete();
      m_illegal = 1'b0;
      m_instret = '0;
      m_valid   = 1'b1;
    end else if (m_valid) begin
      if (fin) m_instret = m_instret + 1'b1;
      if (m_state == FETCH) begin
        if (mem_ready) begin
          m_state = DECODE;
          m_plan.delete();
          case (cls)
            C_ILL:          m_plan = '{TRAP};
            C_LOAD:         m_plan = '{EXEC, MEM, WB};
            C_STORE:        m_plan = '{EXEC, MEM};
            C_BR, C_FENCE:  m_plan = '{EXEC};
            default:        m_plan = '{EXEC, WB};
          endcase
        end
      end else if (m_state != TRAP && !waiting) begin
        if (m_plan.size() > 0) m_state = m_plan.pop_front();
        else m_state = FETCH;
      end
      if (m_state == TRAP) m_illegal = 1'b1;
    end
  endtask

  task automatic step(input logic r, input logic mr, input logic bt, input logic [31:0] ins);
    @(negedge clk);
    rst_n        = r;
    mem_ready    = mr;
    branch_taken = bt;
    instr        = ins;
    #1;
    model_cycle();
  endtask

  localparam logic [31:0] ADDI = 32'h00500093, LW = 32'h0000A103, BEQ = 32'h00000463,
                          JAL = 32'h008000EF, SW = 32'h0020A023, BAD = 32'hFFFFFFFF,
                          NOP = 32'h00000013;

  initial begin
    logic [31:0] cur;
    int          trap_cnt;
    logic        r;

    // Reset and ADDI
    step(1'b0, 1'b1, 1'b0, ADDI);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_pc_we", 32'(pc_we), 32'd0);
    step(1'b0, 1'b1, 1'b0, ADDI);
    step(1'b1, 1'b1, 1'b0, ADDI);
    check("addi_fetch_state", 32'(state), 32'd0);
    check("post_rst_mem_req", 32'(mem_req), 32'd1);
    check("addi_ir_we", 32'(ir_we), 32'd1);
    check("rst_instret", 32'(instret), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    step(1'b1, 1'b1, 1'b0, ADDI);
    check("addi_decode", 32'(state), 32'd1);
    step(1'b1, 1'b1, 1'b0, ADDI);
    check("addi_exec", 32'(state), 32'd2);
    step(1'b1, 1'b1, 1'b0, ADDI);
    check("addi_wb", 32'(state), 32'd4);
    check("addi_reg_we", 32'(reg_we), 32'd1);
    check("addi_wb_sel", 32'(wb_sel), 32'd0);
    check("addi_pc_src", 32'(pc_src), 32'd0);
    check("addi_imm", 32'(alu_src_imm), 32'd1);
    check("addi_pc_we", 32'(pc_we), 32'd1);

    // LW with a 3-cycle memory stall
    step(1'b1, 1'b1, 1'b0, LW);
    check("addi_retire_state", 32'(state), 32'd0);
    check("addi_instret", 32'(instret), 32'd1);
    step(1'b1, 1'b1, 1'b0, LW);
    step(1'b1, 1'b1, 1'b0, LW);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, LW);
      check("lw_wait_state", 32'(state), 32'd3);
      check("lw_wait_mem_req", 32'(mem_req), 32'd1);
      check("lw_wait_mem_we", 32'(mem_we), 32'd0);
    end
    step(1'b1, 1'b1, 1'b0, LW);
    check("lw_mem_req4", 32'(mem_req), 32'd1);
    check("lw_mem_we4", 32'(mem_we), 32'd0);
    step(1'b1, 1'b1, 1'b0, LW);
    check("lw_wb_state", 32'(state), 32'd4);
    check("lw_wb_sel", 32'(wb_sel), 32'd1);
    check("lw_reg_we", 32'(reg_we), 32'd1);

    // BEQ taken then not taken
    step(1'b1, 1'b1, 1'b0, BEQ);
    step(1'b1, 1'b1, 1'b0, BEQ);
    step(1'b1, 1'b1, 1'b1, BEQ);
    check("beq_t_state", 32'(state), 32'd2);
    check("beq_t_pc_we", 32'(pc_we), 32'd1);
    check("beq_t_pc_src", 32'(pc_src), 32'd1);
    check("beq_t_reg_we", 32'(reg_we), 32'd0);
    step(1'b1, 1'b1, 1'b0, BEQ);
    check("beq_t_next", 32'(state), 32'd0);
    step(1'b1, 1'b1, 1'b0, BEQ);
    step(1'b1, 1'b1, 1'b0, BEQ);
    check("beq_nt_pc_we", 32'(pc_we), 32'd1);
    check("beq_nt_pc_src", 32'(pc_src), 32'd0);

    // JAL then SW
    step(1'b1, 1'b1, 1'b0, JAL);
    step(1'b1, 1'b1, 1'b0, JAL);
    step(1'b1, 1'b1, 1'b0, JAL);
    step(1'b1, 1'b1, 1'b0, JAL);
    check("jal_wb_state", 32'(state), 32'd4);
    check("jal_reg_we", 32'(reg_we), 32'd1);
    check("jal_wb_sel", 32'(wb_sel), 32'd2);
    check("jal_pc_src", 32'(pc_src), 32'd1);
    step(1'b1, 1'b1, 1'b0, SW);
    step(1'b1, 1'b1, 1'b0, SW);
    step(1'b1, 1'b1, 1'b0, SW);
    step(1'b1, 1'b1, 1'b0, SW);
    check("sw_mem_state", 32'(state), 32'd3);
    check("sw_mem_we", 32'(mem_we), 32'd1);
    check("sw_pc_we", 32'(pc_we), 32'd1);
    check("sw_reg_we", 32'(reg_we), 32'd0);

    // Illegal opcode traps; six instructions retired so far
    step(1'b1, 1'b1, 1'b0, BAD);
    check("sw_next_state", 32'(state), 32'd0);
    check("sw_next_reg_we", 32'(reg_we), 32'd0);
    step(1'b1, 1'b1, 1'b0, BAD);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), BAD);
      check("trap_state", 32'(state), 32'd5);
      check("trap_illegal", 32'(illegal), 32'd1);
      check("trap_instret", 32'(instret), 32'd6);
      check("trap_pc_we", 32'(pc_we), 32'd0);
      check("trap_mem_req", 32'(mem_req), 32'd0);
    end
    step(1'b0, 1'b1, 1'b0, NOP);
    step(1'b1, 1'b1, 1'b0, NOP);
    check("trap_clr_state", 32'(state), 32'd0);
    check("trap_clr_illegal", 32'(illegal), 32'd0);
    check("trap_clr_instret", 32'(instret), 32'd0);

    // NOP retires without a register write; reset during a MEM wait
    step(1'b1, 1'b1, 1'b0, NOP);
    step(1'b1, 1'b1, 1'b0, NOP);
    step(1'b1, 1'b1, 1'b0, NOP);
    check("nop_reg_we", 32'(reg_we), 32'd0);
    check("nop_pc_we", 32'(pc_we), 32'd1);
    step(1'b1, 1'b1, 1'b0, SW);
    check("nop_instret", 32'(instret), 32'd1);
    step(1'b1, 1'b1, 1'b0, SW);
    step(1'b1, 1'b1, 1'b0, SW);
    step(1'b1, 1'b0, 1'b0, SW);
    check("mem_wait_state", 32'(state), 32'd3);
    step(1'b0, 1'b0, 1'b0, SW);
    check("rst_force_mem_we", 32'(mem_we), 32'd0);
    check("rst_force_mem_req", 32'(mem_req), 32'd0);
    step(1'b1, 1'b0, 1'b0, SW);
    check("mem_rst_state", 32'(state), 32'd0);
    check("mem_rst_instret", 32'(instret), 32'd0);
    check("mem_rst_mem_we", 32'(mem_we), 32'd0);
    check("mem_rst_mem_req", 32'(mem_req), 32'd1);

    // Randomized traffic with occasional resets; instret wraps at 2^BITS
    cur      = NOP;
    trap_cnt = 0;
    for (int i = 0; i < 5000; i++) begin
      if (m_state == FETCH) cur = rand_instr();
      trap_cnt = (m_state == TRAP) ? trap_cnt + 1 : 0;
      r = !(($urandom_range(0, 299) == 0) || (trap_cnt > 6));
      step(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), cur);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter: BITS, default 32, width of the retired-instruction counter.
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port: instr  input  32  instruction register output; stable from DECODE through the last state of the instruction.
REQ-005 Port: mem_ready  input  1  memory handshake completion; ignored while mem_req=0.
REQ-006 Port: branch_taken  input  1  ALU compare result; sampled in EXEC for BRANCH only.
REQ-007 Port: state  output  3  current state encoding.
REQ-008 Port: ir_we  output  1  instruction register load strobe.
REQ-009 Port: pc_we  output  1  PC write strobe.
REQ-010 Port: pc_src  output  2  PC source: 0=pc+4, 1=pc+imm (branch or JAL), 2=rs1+imm (JALR).
REQ-011 Port: mem_req, mem_we  output  1 each  memory request and write qualifier.
REQ-012 Port: reg_we  output  1  register-file write strobe.
REQ-013 Port: wb_sel  output  2  write-back source: 0=ALU, 1=memory, 2=pc+4.
REQ-014 Port: alu_src_imm  output  1  ALU operand B is the immediate.
REQ-015 Port: illegal  output  1  sticky trap flag.
REQ-016 Port: instret  output  BITS  retired-instruction counter.

Function
REQ-017 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=5; encodings 6 and 7 SHALL go to FETCH.
REQ-018 FETCH SHALL assert mem_req=1 and mem_we=0, and SHALL stay in FETCH while mem_ready=0.
REQ-019 On mem_ready=1 in FETCH, ir_we SHALL pulse for that cycle and the next state SHALL be DECODE.
REQ-020 DECODE SHALL last exactly 1 cycle, covering the 1-cycle registered immediate-generator latency, then go to EXEC.
REQ-021 Legal opcodes (instr[6:0]) SHALL be 0000011, 0010011, 0010111, 0100011, 0110011, 0110111, 1100011, 1100111, 1101111 and 0001111 (FENCE); any other opcode SHALL go DECODE -> TRAP.
REQ-022 EXEC routing: LOAD and STORE SHALL go to MEM; OP, OP-IMM, LUI, AUIPC, JAL and JALR SHALL go to WB.
REQ-023 BRANCH in EXEC: pc_we=1, pc_src = branch_taken ? 1 : 0, then FETCH.
REQ-024 FENCE in EXEC: pc_we=1, pc_src=0, then FETCH.
REQ-025 MEM SHALL hold mem_req=1, with mem_we=1 for STORE only, until mem_ready=1.
REQ-026 On mem_ready=1 in MEM: LOAD SHALL go to WB; STORE SHALL assert pc_we=1, pc_src=0 and go to FETCH.
REQ-027 WB SHALL assert pc_we=1 and SHALL then go to FETCH.
REQ-028 WB pc_src SHALL be 1 for JAL, 2 for JALR, and 0 otherwise.
REQ-029 WB wb_sel SHALL be 1 for LOAD, 2 for JAL/JALR, and 0 otherwise.
REQ-030 WB reg_we SHALL equal (instr[11:7] != 0).
REQ-031 alu_src_imm SHALL be 1 in EXEC, MEM and WB for OP-IMM, LOAD, STORE, LUI, AUIPC and JALR; it SHALL be 0 for OP and BRANCH and in all other states.
REQ-032 instret SHALL increment by 1 in every cycle in which pc_we=1, i.e. one increment per retired instruction; it SHALL wrap modulo 2^BITS.
REQ-033 TRAP SHALL be absorbing until reset, with illegal=1 and all strobes (ir_we, pc_we, mem_req, mem_we, reg_we) held at 0.
REQ-034 Any strobe not listed for a state SHALL be 0 in that state; each pc_we pulse SHALL be exactly 1 cycle.

Reset
REQ-035 rst_n=0 sampled at a clock edge SHALL set state=FETCH, illegal=0 and instret=0, from any state, including mid-MEM or mid-FETCH wait.
REQ-036 While rst_n=0, all strobe outputs SHALL be forced to 0 combinationally.
REQ-037 In the first cycle after rst_n returns to 1, mem_req SHALL be 1.

Verification
REQ-038 Reset, then ADDI x1,x0,5 (0x00500093) with mem_ready=1 constantly -> states 0,1,2,4,0; in WB reg_we=1, wb_sel=0, pc_src=0, alu_src_imm=1; instret goes 0 -> 1.
REQ-039 LW x2,0(x1) (0x0000A103) with mem_ready low for 3 cycles in MEM -> mem_req=1 for 4 MEM cycles with mem_we=0, then WB with wb_sel=1 and reg_we=1.
REQ-040 BEQ (0x00000463): with branch_taken=1 -> EXEC pc_we=1, pc_src=1, reg_we=0, next state FETCH; with branch_taken=0 -> pc_src=0.
REQ-041 JAL x1 (0x008000EF) -> WB reg_we=1, wb_sel=2, pc_src=1. SW (0x0020A023) -> MEM mem_we=1, then FETCH with no reg_we.
REQ-042 Instr 0xFFFFFFFF -> TRAP with illegal=1 held for 20 cycles and instret unchanged; a 1-cycle rst_n=0 pulse -> FETCH, illegal=0.
REQ-043 NOP (0x00000013) -> WB reg_we=0 and instret increments; rst_n=0 during a MEM wait -> FETCH next cycle, instret=0, mem_we=0.
